// File: rtl/huffman_bit_packer_if.sv
// ---------------------------------------------------------------------------
// huffman_bit_packer_if
//   Groups the serial-bit input side and the byte output side of the
//   Huffman bit packer into one bundle.
//   master : producer of bits / consumer of bytes (testbench or upstream)
//   slave  : the packer itself
// Signals:
//   bit_in, bit_valid   serial code bit and its qualifier
//   flush               close the current partial byte
//   byte_out[7:0]       head byte of the output FIFO
//   byte_valid          FIFO non-empty
//   byte_ready          consumer accept (pop on byte_valid & byte_ready)
//   byte_last           head byte was closed by flush
//   pad_bits[2:0]       zero-pad bit count of the head byte
//   overflow            sticky, set when a byte was dropped
// ---------------------------------------------------------------------------
interface huffman_bit_packer_if;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic [2:0] pad_bits;
  logic       overflow;

  modport master (
    output bit_in, bit_valid, flush, byte_ready,
    input  byte_out, byte_valid, byte_last, pad_bits, overflow
  );

  modport slave (
    input  bit_in, bit_valid, flush, byte_ready,
    output byte_out, byte_valid, byte_last, pad_bits, overflow
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// ---------------------------------------------------------------------------
// huffman_bit_packer
//   Packs a serial Huffman code bit stream into bytes and queues them in a
//   2-entry output FIFO. A flush closes a partial byte, zero-padding it and
//   tagging it as last with its pad count.
// Ports:
//   clock   sole clock, rising edge
//   reset   synchronous, active-high; clears packer, FIFO and overflow
//   bus     huffman_bit_packer_if.slave (bit input, byte output, overflow)
// Configuration:
//   HUFFMAN_PACKER_MSB_FIRST_EN  defined   : first bit lands in byte_out[7],
//                                            padding fills the low bits
//                                undefined : first bit lands in byte_out[0],
//                                            padding fills the high bits
// ---------------------------------------------------------------------------
module huffman_bit_packer (
  input  logic                  clock,
  input  logic                  reset,
  huffman_bit_packer_if.slave   bus
);

  typedef struct packed {
    logic       last;
    logic [2:0] pad;
    logic [7:0] data;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '{last: 1'b0, pad: 3'd0, data: 8'd0};

  // Packer state
  logic [7:0] r_shift;
  logic [2:0] r_count;

  // FIFO state: r_head is the presented entry, r_tail the one behind it
  entry_t     r_head;
  entry_t     r_tail;
  logic [1:0] r_occ;
  logic       r_valid;
  logic       r_overflow;

  // Combinational next-state
  logic [2:0] w_bit_pos;
  logic [7:0] w_shift_app;
  logic [2:0] w_count_inc;
  logic       w_byte_done;
  logic       w_partial;
  logic       w_push;
  entry_t     w_push_entry;
  logic [7:0] w_shift_nxt;
  logic [2:0] w_count_nxt;
  logic       w_pop;
  logic       w_drop;
  entry_t     w_head_nxt;
  entry_t     w_tail_nxt;
  logic [1:0] w_occ_nxt;

  // Slot the incoming bit takes depends on the configured bit order
`ifdef HUFFMAN_PACKER_MSB_FIRST_EN
  assign w_bit_pos = 3'd7 - r_count;
`else
  assign w_bit_pos = r_count;
`endif

  // Bit assembly and flush handling; flush sees the same-cycle bit first
  always_comb begin
    w_shift_app  = r_shift;
    w_count_inc  = r_count;
    w_push_entry = ENTRY_ZERO;
    if (bus.bit_valid) begin
      w_shift_app[w_bit_pos] = bus.bit_in;
      w_count_inc            = r_count + 3'd1;
    end else begin
      w_shift_app = r_shift;
      w_count_inc = r_count;
    end
    w_byte_done = bus.bit_valid && (r_count == 3'd7);
    // A completed byte always leaves the count at 0, so this is exclusive
    w_partial   = bus.flush && (w_count_inc != 3'd0);
    w_push      = w_byte_done || w_partial;

    w_push_entry.data = w_shift_app;
    w_push_entry.last = bus.flush;
    // 8-k in three bits is simply -k; a full byte carries no padding
    if (w_partial) begin
      w_push_entry.pad = 3'd0 - w_count_inc;
    end else begin
      w_push_entry.pad = 3'd0;
    end

    // Unused slots are kept zero so padding comes out as zeros
    if (w_push) begin
      w_shift_nxt = 8'd0;
      w_count_nxt = 3'd0;
    end else begin
      w_shift_nxt = w_shift_app;
      w_count_nxt = w_count_inc;
    end
  end

  // Two-entry FIFO next-state with same-cycle pop/push and drop on full
  always_comb begin
    w_pop      = r_valid && bus.byte_ready;
    w_drop     = 1'b0;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    w_occ_nxt  = r_occ;
    case ({w_push, w_pop})
      2'b00: begin
        w_occ_nxt = r_occ;
      end
      2'b01: begin
        if (r_occ == 2'd2) begin
          w_head_nxt = r_tail;
          w_tail_nxt = ENTRY_ZERO;
          w_occ_nxt  = 2'd1;
        end else begin
          w_head_nxt = ENTRY_ZERO;
          w_occ_nxt  = 2'd0;
        end
      end
      2'b10: begin
        case (r_occ)
          2'd0: begin
            w_head_nxt = w_push_entry;
            w_occ_nxt  = 2'd1;
          end
          2'd1: begin
            w_tail_nxt = w_push_entry;
            w_occ_nxt  = 2'd2;
          end
          default: begin
            w_drop = 1'b1;
          end
        endcase
      end
      2'b11: begin
        // Pop frees a slot, so occupancy is unchanged
        if (r_occ == 2'd2) begin
          w_head_nxt = r_tail;
          w_tail_nxt = w_push_entry;
        end else begin
          w_head_nxt = w_push_entry;
        end
      end
      default: begin
        w_occ_nxt = r_occ;
      end
    endcase
  end

  // State registers; reset wins over every input
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift    <= 8'd0;
      r_count    <= 3'd0;
      r_head     <= ENTRY_ZERO;
      r_tail     <= ENTRY_ZERO;
      r_occ      <= 2'd0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_count    <= w_count_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_occ      <= w_occ_nxt;
      r_valid    <= (w_occ_nxt != 2'd0);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign bus.byte_out   = r_head.data;
  assign bus.byte_last  = r_head.last;
  assign bus.pad_bits   = r_head.pad;
  assign bus.byte_valid = r_valid;
  assign bus.overflow   = r_overflow;

endmodule
